// File: rtl/dvp_pkg.sv
// Shared types and constants for the DVP pixel receiver.
package dvp_pkg;

    // Capture state machine
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_VBLANK = 2'd2,
        ST_ACTIVE = 2'd3
    } dvp_state_e;

    // Bit positions inside err_o
    localparam int unsigned ERR_LEN  = 0;
    localparam int unsigned ERR_CNT  = 1;
    localparam int unsigned ERR_PART = 2;
    localparam int unsigned ERR_W    = 3;

    localparam int unsigned FRAME_CNT_W = 16;

    // Beat counter width; a single-beat pixel still needs one bit of storage
    function automatic int unsigned beat_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/dvp_beat_packer.sv
// Collects BEATS bus words into one pixel word. done_o fires combinationally
// in the cycle the final beat is presented, with word_o already holding it.
module dvp_beat_packer
    import dvp_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BEATS     = 2,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     beat_en_i,
    input  logic [DATA_W-1:0]        d_i,
    output logic [DATA_W*BEATS-1:0]  word_o,
    output logic                     done_o,
    output logic                     partial_o
);

    localparam int unsigned BCW = beat_cnt_w(BEATS);

    logic [BCW-1:0]          beat_q, beat_d;
    logic [DATA_W*BEATS-1:0] slots_q, slots_d;
    logic [DATA_W*BEATS-1:0] merged;
    int unsigned             slot;

    // Merge the incoming beat into its slot and compute the next counter value
    always_comb begin
        if (MSB_FIRST != 0) begin
            slot = BEATS - 1 - 32'(beat_q);
        end else begin
            slot = 32'(beat_q);
        end
        merged = slots_q;
        merged[slot*DATA_W +: DATA_W] = d_i;
        done_o = beat_en_i && (beat_q == BCW'(BEATS - 1));
        slots_d = slots_q;
        beat_d  = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (beat_en_i) begin
            slots_d = merged;
            beat_d  = done_o ? '0 : beat_q + BCW'(1);
        end
    end

    // Slot storage and beat counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            slots_q <= '0;
        end else begin
            beat_q  <= beat_d;
            slots_q <= slots_d;
        end
    end

    assign word_o    = merged;
    assign partial_o = (beat_q != '0);

endmodule

// File: rtl/dvp_pixel_rx.sv
// DVP (VSYNC/HREF/PCLK) pixel receiver: frame sync, pixel assembly,
// coordinates, frame/line tagging and geometry checking, all in PCLK domain.
module dvp_pixel_rx
    import dvp_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BEATS     = 2,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned VSYNC_ACT = 1,
    parameter int unsigned COORD_W   = 12
) (
    input  logic                     pclk_i,
    input  logic                     rst_i,
    input  logic [DATA_W-1:0]        d_i,
    input  logic                     vsync_i,
    input  logic                     href_i,
    input  logic                     enable_i,
    input  logic [COORD_W-1:0]       width_i,
    input  logic [COORD_W-1:0]       height_i,
    output logic                     pixel_valid_o,
    output logic [DATA_W*BEATS-1:0]  pixel_o,
    output logic                     sof_o,
    output logic                     sol_o,
    output logic [COORD_W-1:0]       x_o,
    output logic [COORD_W-1:0]       y_o,
    output logic                     eof_o,
    output logic [FRAME_CNT_W-1:0]   frame_cnt_o,
    output logic [ERR_W-1:0]         err_o
);

    dvp_state_e               state_q;
    logic                     href_q;
    logic [COORD_W-1:0]       x_q, y_q;
    logic                     sof_arm_q, sol_arm_q;
    logic                     pixel_valid_q, sof_q, sol_q, eof_q;
    logic [DATA_W*BEATS-1:0]  pixel_q;
    logic [COORD_W-1:0]       x_out_q, y_out_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic [ERR_W-1:0]         err_q;

    logic                     vs_act, line_end, cap_en, pk_clr;
    logic [DATA_W*BEATS-1:0]  pk_word;
    logic                     pk_done, pk_partial;

    // Bus decode: sync level, line end, and when the packer may take a beat
    always_comb begin
        vs_act   = (VSYNC_ACT != 0) ? vsync_i : ~vsync_i;
        line_end = href_q && !href_i;
        cap_en   = (state_q == ST_ACTIVE) && !vs_act && href_i;
        pk_clr   = (state_q != ST_ACTIVE) || vs_act || line_end;
    end

    dvp_beat_packer #(
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk_i     (pclk_i),
        .rst_i     (rst_i),
        .clr_i     (pk_clr),
        .beat_en_i (cap_en),
        .d_i       (d_i),
        .word_o    (pk_word),
        .done_o    (pk_done),
        .partial_o (pk_partial)
    );

    // Capture FSM with counters, tagging, error tracking and registered outputs
    always_ff @(posedge pclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            href_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            sof_arm_q     <= 1'b0;
            sol_arm_q     <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_q       <= '0;
            sof_q         <= 1'b0;
            sol_q         <= 1'b0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            eof_q         <= 1'b0;
            frame_cnt_q   <= '0;
            err_q         <= '0;
        end else begin
            href_q        <= href_i;
            pixel_valid_q <= 1'b0;
            sof_q         <= 1'b0;
            sol_q         <= 1'b0;
            eof_q         <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (vs_act) begin
                        state_q <= ST_VBLANK;
                    end
                end
                ST_VBLANK: begin
                    x_q       <= '0;
                    y_q       <= '0;
                    sof_arm_q <= 1'b1;
                    sol_arm_q <= 1'b1;
                    if (!vs_act) begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (vs_act) begin
                        // Frame end takes priority over any beat on the bus
                        eof_q       <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                        if (y_q != height_i) begin
                            err_q[ERR_CNT] <= 1'b1;
                        end
                        state_q <= enable_i ? ST_VBLANK : ST_IDLE;
                    end else if (line_end) begin
                        if (pk_partial) begin
                            err_q[ERR_PART] <= 1'b1;
                        end
                        if (x_q != width_i) begin
                            err_q[ERR_LEN] <= 1'b1;
                        end
                        x_q       <= '0;
                        y_q       <= (y_q == '1) ? y_q : y_q + COORD_W'(1);
                        sol_arm_q <= 1'b1;
                    end else if (pk_done) begin
                        pixel_valid_q <= 1'b1;
                        pixel_q       <= pk_word;
                        x_out_q       <= x_q;
                        y_out_q       <= y_q;
                        sof_q         <= sof_arm_q;
                        sol_q         <= sol_arm_q | sof_arm_q;
                        x_q           <= (x_q == '1) ? x_q : x_q + COORD_W'(1);
                        sof_arm_q     <= 1'b0;
                        sol_arm_q     <= 1'b0;
                        if (sof_arm_q) begin
                            err_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pixel_valid_o = pixel_valid_q;
    assign pixel_o       = pixel_q;
    assign sof_o         = sof_q;
    assign sol_o         = sol_q;
    assign x_o           = x_out_q;
    assign y_o           = y_out_q;
    assign eof_o         = eof_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_o         = err_q;

endmodule
